// File: rtl/wb_openram_arbiter.sv
// Two Wishbone classic slave ports sharing one 1RW OpenRAM macro port; all macro outputs registered.
// Define WB_OPENRAM_ARB_PRIO_EN for fixed A-over-B priority; the default build uses round-robin.
module wb_openram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rstn_i,

    input  logic                    wbs_a_cyc_i,
    input  logic                    wbs_a_stb_i,
    input  logic                    wbs_a_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_a_sel_i,
    input  logic [31:0]             wbs_a_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_a_dat_i,
    output logic                    wbs_a_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_a_dat_o,

    input  logic                    wbs_b_cyc_i,
    input  logic                    wbs_b_stb_i,
    input  logic                    wbs_b_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_b_sel_i,
    input  logic [31:0]             wbs_b_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_b_dat_i,
    output logic                    wbs_b_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_b_dat_o,

    output logic                    ram_csb_o,
    output logic                    ram_web_o,
    output logic [DATA_WIDTH/8-1:0] ram_wmask_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_din_o,
    input  logic [DATA_WIDTH-1:0]   ram_dout_i
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT,
        ACK
    } state_t;

    state_t                r_state;
    logic                  r_grantB;
    logic                  r_csb;
    logic                  r_web;
    logic [SEL_WIDTH-1:0]  r_wmask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_ackA;
    logic                  r_ackB;
    logic [DATA_WIDTH-1:0] r_datA;
    logic [DATA_WIDTH-1:0] r_datB;
`ifndef WB_OPENRAM_ARB_PRIO_EN
    logic                  r_lastB;
`endif

    logic                  w_reqA;
    logic                  w_reqB;
    logic                  w_pickB;
    logic                  w_we;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic                  w_unused;

    assign w_reqA = wbs_a_cyc_i & wbs_a_stb_i;
    assign w_reqB = wbs_b_cyc_i & wbs_b_stb_i;

`ifdef WB_OPENRAM_ARB_PRIO_EN
    assign w_pickB = ~w_reqA;
`else
    // On a tie the port that was not served last time wins.
    assign w_pickB = w_reqB & (~w_reqA | ~r_lastB);
`endif

    assign w_we   = w_pickB ? wbs_b_we_i  : wbs_a_we_i;
    assign w_sel  = w_pickB ? wbs_b_sel_i : wbs_a_sel_i;
    assign w_addr = w_pickB ? wbs_b_adr_i[ADDR_WIDTH+1:2] : wbs_a_adr_i[ADDR_WIDTH+1:2];
    assign w_din  = w_pickB ? wbs_b_dat_i : wbs_a_dat_i;

    // Upper address bits are decoded upstream; byte-offset bits are covered by sel.
    assign w_unused = ^{wbs_a_adr_i[31:ADDR_WIDTH+2], wbs_a_adr_i[1:0],
                        wbs_b_adr_i[31:ADDR_WIDTH+2], wbs_b_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state  <= IDLE;
            r_grantB <= 1'b0;
            r_csb    <= 1'b1;
            r_web    <= 1'b1;
            r_wmask  <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_ackA   <= 1'b0;
            r_ackB   <= 1'b0;
            r_datA   <= '0;
            r_datB   <= '0;
`ifndef WB_OPENRAM_ARB_PRIO_EN
            r_lastB  <= 1'b1;
`endif
        end else begin
            r_ackA <= 1'b0;
            r_ackB <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_reqA || w_reqB) begin
                        r_grantB <= w_pickB;
                        r_addr   <= w_addr;
                        r_din    <= w_din;
                        r_web    <= ~w_we;
                        r_wmask  <= w_we ? w_sel : '0;
                        r_csb    <= 1'b0;
`ifndef WB_OPENRAM_ARB_PRIO_EN
                        r_lastB  <= w_pickB;
`endif
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_csb <= 1'b1;
                    if (r_web) begin
                        r_state <= RDWAIT;
                    end else begin
                        r_ackA  <= ~r_grantB;
                        r_ackB  <= r_grantB;
                        r_state <= ACK;
                    end
                end
                RDWAIT: begin
                    // Macro read data is valid for the whole cycle after its capture edge.
                    if (r_grantB) begin
                        r_datB <= ram_dout_i;
                    end else begin
                        r_datA <= ram_dout_i;
                    end
                    r_ackA  <= ~r_grantB;
                    r_ackB  <= r_grantB;
                    r_state <= ACK;
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram_csb_o   = r_csb;
    assign ram_web_o   = r_web;
    assign ram_wmask_o = r_wmask;
    assign ram_addr_o  = r_addr;
    assign ram_din_o   = r_din;
    assign wbs_a_ack_o = r_ackA;
    assign wbs_a_dat_o = r_datA;
    assign wbs_b_ack_o = r_ackB;
    assign wbs_b_dat_o = r_datB;

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Self-checking bench for wb_openram_arbiter: random masters, a macro model and a timeline reference model.
// Expectations adapt to WB_OPENRAM_ARB_PRIO_EN when the design is built with it.
module tb_wb_openram_arbiter;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int MAXTX = 512;

    typedef struct packed {
        logic          we;
        logic [SW-1:0] sel;
        logic [31:0]   adr;
        logic [DW-1:0] dat;
        logic [7:0]    gap;
    } txn_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tickCount = 0;
    int   errors = 0;
    int   checks = 0;
    int   bothAck = 0;

    logic          mCyc [2];
    logic          mStb [2];
    logic          mWe  [2];
    logic [SW-1:0] mSel [2];
    logic [31:0]   mAdr [2];
    logic [DW-1:0] mDat [2];

    logic          ackA, ackB;
    logic [DW-1:0] datA, datB;
    logic          ramCsb, ramWeb;
    logic [SW-1:0] ramWmask;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramDin;
    logic [DW-1:0] ramDout = '0;
    logic [DW-1:0] macroMem [256] = '{default: '0};

    txn_t          txq [2][MAXTX];
    int            head [2] = '{0, 0};
    int            tail [2] = '{0, 0};
    logic          active [2];
    int            waitCnt [2];
    int            startTick [2];
    int            lastLatency [2];
    int            doneCount [2];
    logic [DW-1:0] lastRdata [2];
    int            ackOrder [$];

    logic          ackSeen [2] = '{1'b0, 1'b0};
    logic [DW-1:0] datSeen [2];
    int            ackTickSeen [2] = '{0, 0};
    logic [AW-1:0] accAddrLog [$];
    logic [SW-1:0] accMaskLog [$];

    logic          pending = 1'b0;
    int            pPort;
    logic          pWe;
    logic [AW-1:0] pAddr;
    logic [SW-1:0] pMask;
    logic [DW-1:0] pDin;
    logic [DW-1:0] pRdata;
    int            accTick;
    int            ackTickExp;
    int            freeTick = 0;
`ifndef WB_OPENRAM_ARB_PRIO_EN
    int            lastGrant = 1;
`endif
    logic [DW-1:0] modelDat [2] = '{'0, '0};
    logic [DW-1:0] refMem [256] = '{default: '0};
    logic          reqA, reqB, expCsb;
    logic          expAck [2];
    int            w;

    wb_openram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .wb_clk_i    (clk),
        .wb_rstn_i   (rstn),
        .wbs_a_cyc_i (mCyc[0]),
        .wbs_a_stb_i (mStb[0]),
        .wbs_a_we_i  (mWe[0]),
        .wbs_a_sel_i (mSel[0]),
        .wbs_a_adr_i (mAdr[0]),
        .wbs_a_dat_i (mDat[0]),
        .wbs_a_ack_o (ackA),
        .wbs_a_dat_o (datA),
        .wbs_b_cyc_i (mCyc[1]),
        .wbs_b_stb_i (mStb[1]),
        .wbs_b_we_i  (mWe[1]),
        .wbs_b_sel_i (mSel[1]),
        .wbs_b_adr_i (mAdr[1]),
        .wbs_b_dat_i (mDat[1]),
        .wbs_b_ack_o (ackB),
        .wbs_b_dat_o (datB),
        .ram_csb_o   (ramCsb),
        .ram_web_o   (ramWeb),
        .ram_wmask_o (ramWmask),
        .ram_addr_o  (ramAddr),
        .ram_din_o   (ramDin),
        .ram_dout_i  (ramDout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tickCount <= tickCount + 1;

    // Macro behaviour: writes and reads happen at the edge closing a csb-low cycle.
    always @(posedge clk) begin
        if (!ramCsb) begin
            if (!ramWeb) begin
                for (int b = 0; b < SW; b++) begin
                    if (ramWmask[b]) macroMem[ramAddr][8*b +: 8] <= ramDin[8*b +: 8];
                end
            end else begin
                ramDout <= macroMem[ramAddr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [SW-1:0] sel,
                                 input logic [31:0] adr, input logic [DW-1:0] dat, input int gap);
        if (tail[port] >= MAXTX) begin
            checks++;
            errors++;
            $display("[TB] FAIL txq_overflow: port %0d tail %0d, limit %0d", port, tail[port], MAXTX);
        end else begin
            txq[port][tail[port]] = {we, sel, adr, dat, 8'(gap)};
            tail[port] = tail[port] + 1;
        end
    endtask

    task automatic applyReset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while ((head[0] != tail[0] || head[1] != tail[1]) && n < limit) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_timeout: still busy after %0d cycles, required idle", n);
        end
        @(negedge clk);
    endtask

    // Bus masters: hold a request until acked, then fetch the next queued transfer.
    initial begin
        for (int p = 0; p < 2; p++) begin
            mCyc[p] = 1'b0; mStb[p] = 1'b0; mWe[p] = 1'b0; mSel[p] = '0;
            mAdr[p] = '0; mDat[p] = '0; active[p] = 1'b0; waitCnt[p] = 0;
            startTick[p] = 0; lastLatency[p] = 0; doneCount[p] = 0; lastRdata[p] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (!rstn) begin
                    active[p] = 1'b0;
                    head[p]   = tail[p];
                    waitCnt[p] = 0;
                    mCyc[p]   = 1'b0;
                    mStb[p]   = 1'b0;
                end else begin
                    if (active[p] && ackSeen[p]) begin
                        if (!txq[p][head[p]].we) lastRdata[p] = datSeen[p];
                        lastLatency[p] = ackTickSeen[p] - startTick[p];
                        doneCount[p]++;
                        ackOrder.push_back(p);
                        head[p]   = head[p] + 1;
                        active[p] = 1'b0;
                        waitCnt[p] = 0;
                    end
                    if (!active[p] && head[p] != tail[p] && waitCnt[p] >= int'(txq[p][head[p]].gap)) begin
                        mCyc[p] = 1'b1;
                        mStb[p] = 1'b1;
                        mWe[p]  = txq[p][head[p]].we;
                        mSel[p] = txq[p][head[p]].sel;
                        mAdr[p] = txq[p][head[p]].adr;
                        mDat[p] = txq[p][head[p]].dat;
                        active[p]    = 1'b1;
                        startTick[p] = tickCount;
                    end else if (!active[p]) begin
                        if (head[p] == tail[p]) waitCnt[p] = 0;
                        else waitCnt[p]++;
                        case ($urandom_range(0, 2))
                            0: begin mCyc[p] = 1'b0; mStb[p] = 1'b0; end
                            1: begin mCyc[p] = 1'b1; mStb[p] = 1'b0; end
                            default: begin mCyc[p] = 1'b0; mStb[p] = 1'b1; end
                        endcase
                        mWe[p]  = 1'($urandom);
                        mSel[p] = SW'($urandom);
                        mAdr[p] = $urandom;
                        mDat[p] = $urandom;
                    end
                end
            end
        end
    end

    // Reference model: one transfer at a time on a cycle timeline, checked every cycle.
    initial begin
        forever begin
            @(negedge clk);
            ackSeen[0] = ackA;
            ackSeen[1] = ackB;
            datSeen[0] = datA;
            datSeen[1] = datB;
            for (int p = 0; p < 2; p++) if (ackSeen[p]) ackTickSeen[p] = tickCount;
            if (ackA && ackB) bothAck++;
            if (!rstn) begin
                pending  = 1'b0;
                freeTick = 0;
                modelDat[0] = '0;
                modelDat[1] = '0;
`ifndef WB_OPENRAM_ARB_PRIO_EN
                lastGrant = 1;
`endif
                checkOutput("rst_csb", ramCsb, 1);
                checkOutput("rst_web", ramWeb, 1);
                checkOutput("rst_wmask", ramWmask, 0);
                checkOutput("rst_addr", ramAddr, 0);
                checkOutput("rst_din", ramDin, 0);
                checkOutput("rst_ackA", ackA, 0);
                checkOutput("rst_ackB", ackB, 0);
                checkOutput("rst_datA", datA, 0);
                checkOutput("rst_datB", datB, 0);
            end else begin
                if (!ramCsb) begin
                    accAddrLog.push_back(ramAddr);
                    accMaskLog.push_back(ramWmask);
                end
                expCsb = 1'b1;
                expAck[0] = 1'b0;
                expAck[1] = 1'b0;
                if (pending && tickCount == accTick) begin
                    expCsb = 1'b0;
                    if (pWe) begin
                        for (int b = 0; b < SW; b++) if (pMask[b]) refMem[pAddr][8*b +: 8] = pDin[8*b +: 8];
                    end else begin
                        pRdata = refMem[pAddr];
                    end
                    checkOutput("acc_addr", ramAddr, pAddr);
                    checkOutput("acc_web", ramWeb, !pWe);
                    checkOutput("acc_wmask", ramWmask, pMask);
                    checkOutput("acc_din", ramDin, pDin);
                end
                if (pending && tickCount == ackTickExp) begin
                    expAck[pPort] = 1'b1;
                    if (!pWe) modelDat[pPort] = pRdata;
                    pending  = 1'b0;
                    freeTick = tickCount + 1;
                end
                checkOutput("csb", ramCsb, expCsb);
                checkOutput("ackA", ackA, expAck[0]);
                checkOutput("ackB", ackB, expAck[1]);
                checkOutput("datA", datA, modelDat[0]);
                checkOutput("datB", datB, modelDat[1]);
                if (!pending && tickCount >= freeTick) begin
                    reqA = mCyc[0] && mStb[0];
                    reqB = mCyc[1] && mStb[1];
                    if (reqA || reqB) begin
`ifdef WB_OPENRAM_ARB_PRIO_EN
                        w = reqA ? 0 : 1;
`else
                        if (reqA && reqB) w = (lastGrant == 1) ? 0 : 1;
                        else w = reqA ? 0 : 1;
                        lastGrant = w;
`endif
                        pending    = 1'b1;
                        pPort      = w;
                        pWe        = mWe[w];
                        pAddr      = mAdr[w][AW+1:2];
                        pMask      = mWe[w] ? mSel[w] : '0;
                        pDin       = mDat[w];
                        accTick    = tickCount + 1;
                        ackTickExp = tickCount + (mWe[w] ? 2 : 3);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int expPort;
        $display("[TB] starting wb_openram_arbiter bench");
        applyReset();

        // Write then read back through port A.
        applyStimulus(0, 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 0);
        waitDone(100);
        checkOutput("t1_wr_addr", accAddrLog[$], 8'h04);
        checkOutput("t1_wr_latency", lastLatency[0], 2);
        applyStimulus(0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, 0);
        waitDone(100);
        checkOutput("t1_rd_latency", lastLatency[0], 3);
        checkOutput("t1_rd_data", lastRdata[0], 32'hDEAD_BEEF);

        // Byte-lane write merge.
        applyStimulus(0, 1'b1, 4'hF, 32'h3000_0020, 32'h1122_3344, 0);
        applyStimulus(0, 1'b1, 4'b0010, 32'h3000_0020, 32'hAABB_CCDD, 0);
        applyStimulus(0, 1'b0, 4'hF, 32'h3000_0020, 32'h0, 0);
        waitDone(100);
        checkOutput("t2_rd_data", lastRdata[0], 32'h1122_CC44);
        checkOutput("t2_mask", accMaskLog[accMaskLog.size()-2], 4'b0010);

        // Simultaneous reads after reset, then sustained contention.
        applyStimulus(0, 1'b1, 4'hF, 32'h0000_0040, 32'hA5A5_A5A5, 0);
        applyStimulus(0, 1'b1, 4'hF, 32'h0000_0080, 32'h5A5A_5A5A, 0);
        waitDone(100);
        applyReset();
        base = ackOrder.size();
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 0);
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0080, 32'h0, 0);
        waitDone(100);
        checkOutput("t3_count", ackOrder.size() - base, 2);
        checkOutput("t3_first", ackOrder[base], 0);
        checkOutput("t3_second", ackOrder[base+1], 1);
        checkOutput("t3_datA", lastRdata[0], 32'hA5A5_A5A5);
        checkOutput("t3_datB", lastRdata[1], 32'h5A5A_5A5A);
        base = ackOrder.size();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 0);
            applyStimulus(1, 1'b0, 4'hF, 32'h0000_0080, 32'h0, 0);
        end
        waitDone(200);
        checkOutput("t3_alt_count", ackOrder.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
`ifdef WB_OPENRAM_ARB_PRIO_EN
            expPort = (i < 3) ? 0 : 1;
`else
            expPort = i % 2;
`endif
            checkOutput($sformatf("t3_order%0d", i), ackOrder[base+i], expPort);
        end

        // Asynchronous reset while a port B read sits in RDWAIT.
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0080, 32'h0, 0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("t4_pre_datB", datB, 32'h5A5A_5A5A);
        rstn = 1'b0;
        #1;
        checkOutput("t4_csb", ramCsb, 1);
        checkOutput("t4_addr", ramAddr, 0);
        checkOutput("t4_ackA", ackA, 0);
        checkOutput("t4_ackB", ackB, 0);
        checkOutput("t4_datA", datA, 0);
        checkOutput("t4_datB", datB, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 0);
        waitDone(100);
        checkOutput("t4_rd_latency", lastLatency[1], 3);
        checkOutput("t4_rd_data", lastRdata[1], 32'hA5A5_A5A5);

        // Port B bursts 8 writes against a continuously requesting port A.
        base = ackOrder.size();
        for (int i = 0; i < 20; i++) applyStimulus(0, 1'b1, 4'hF, {22'h0, 8'(i), 2'b00}, $urandom, 0);
        for (int i = 0; i < 8; i++)  applyStimulus(1, 1'b1, 4'hF, {22'h0, 8'(32 + i), 2'b00}, $urandom, 0);
        waitDone(400);
        checkOutput("t5_count", ackOrder.size() - base, 28);
        for (int i = 0; i < 28; i++) begin
`ifdef WB_OPENRAM_ARB_PRIO_EN
            expPort = (i < 20) ? 0 : 1;
`else
            expPort = (i < 16) ? (i % 2) : 0;
`endif
            checkOutput($sformatf("t5_order%0d", i), ackOrder[base+i], expPort);
        end

        // Random traffic on both ports, including sel=0 writes and idle noise.
        for (int i = 0; i < 160; i++) begin
            logic [31:0] adr;
            adr = $urandom;
            adr[AW+1:2] = AW'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 1), 1'($urandom), SW'($urandom), adr, $urandom,
                          $urandom_range(0, 3));
        end
        waitDone(5000);

        checkOutput("no_dual_ack", bothAck, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_openram_arbiter.md
Name: wb_openram_arbiter

Overview:
Shares one single-port (1RW) OpenRAM macro port between two Wishbone classic slave ports.
- Port A serves the management SoC.
- Port B serves a user-project master.
The block sits in the user project area, between the Wishbone fabric and the macro's port 0. It arbitrates between the two ports, sequences the macro's chip-select, write-enable and mask, and returns data and ack to the granted requester.

Parameters:
- ADDR_WIDTH, 8, macro word-address width; Wishbone byte address bits [ADDR_WIDTH+1:2] are used.
- DATA_WIDTH, 32, data width; must be a multiple of 8. SEL width is DATA_WIDTH/8.

Ports:
- wb_clk_i  in  1  single clock for the Wishbone side and the macro.
- wb_rstn_i  in  1  asynchronous active-low reset.
- wbs_a_cyc_i, wbs_a_stb_i, wbs_a_we_i  in  1 each  port A cycle, strobe, write enable.
- wbs_a_sel_i  in  DATA_WIDTH/8  port A byte selects.
- wbs_a_adr_i  in  32  port A byte address.
- wbs_a_dat_i  in  DATA_WIDTH  port A write data.
- wbs_a_ack_o  out  1  port A acknowledge.
- wbs_a_dat_o  out  DATA_WIDTH  port A read data.
- wbs_b_*: same set as port A, for port B.
- ram_csb_o  out  1  macro chip select, active low.
- ram_web_o  out  1  macro write enable, active low.
- ram_wmask_o  out  DATA_WIDTH/8  macro byte write mask.
- ram_addr_o  out  ADDR_WIDTH  macro word address.
- ram_din_o  out  DATA_WIDTH  macro write data.
- ram_dout_i  in  DATA_WIDTH  macro read data.

Behaviour:
- A port requests when cyc & stb are both high.
- All macro outputs are registered. No combinational path from wbs_* inputs to ram_* outputs.
- Reset values:
  - ram_csb_o=1, ram_web_o=1, ram_wmask_o=0, ram_addr_o=0, ram_din_o=0.
  - Both ack=0, both dat_o=0.
  - state=IDLE, last_grant=B (so A wins the first tie).
- State machine:
  - IDLE:
    - No request: csb stays 1.
    - One request: grant that port.
    - Both requesting: grant the port that is not last_grant (round-robin).
    - On grant, at the clock edge: register addr and din; web=~we; wmask=we?sel:0; csb=0; last_grant=winner; go to ACCESS.
  - ACCESS (cycle 1, csb low): the macro captures at the end of this cycle.
    - Next state: csb=1. Write goes to ACK. Read goes to RDWAIT.
  - RDWAIT (read only, cycle 2): capture ram_dout_i into the granted port's dat_o register. Go to ACK.
  - ACK: assert the granted port's ack for exactly one cycle. Go to IDLE.
- Latency from request sampled in IDLE (cycle 0) to ack high:
  - Write: cycle 2.
  - Read: cycle 3.
- Throughput: at most one transfer every 3 cycles (write) or 4 cycles (read).
- The non-granted port's ack stays 0. Its request is held by its master and served next.
- dat_o of each port holds its last read value until the next read to that port. Writes do not modify dat_o.
- A request that is withdrawn (stb dropped) after grant still completes on the macro. The ack is still pulsed; a compliant master ignores it.
- Mid-transfer request changes are ignored. Address, data, we and sel are latched at grant only.
- ack is never asserted to both ports in the same cycle.
- A sel=0 write still performs the macro cycle with wmask=0 and is acked.
- Address bits above ADDR_WIDTH+1 are ignored; decode is done upstream.
- Reset asserted in any state: all outputs go to their reset values immediately (asynchronous) and the in-flight transfer is dropped with no ack. After release, IDLE is entered and re-arbitration starts from last_grant=B.

Optional Feature:
- Macro: WB_OPENRAM_ARB_PRIO_EN.
- Defined: fixed priority. Port A always wins when both ports request. last_grant is unused and port B can be starved.
- Undefined (default): round-robin as specified above.

Test Plan:
1. Port A writes 0xDEADBEEF to byte addr 0x3000_0010 (sel=4'hF), then reads it back.
   -> ram_addr_o=8'h04; write ack at cycle 2; read ack at cycle 3 with wbs_a_dat_o=0xDEADBEEF.
2. Byte-lane write: write 0x11223344 (sel=F), then 0xAABBCCDD with sel=4'b0010 to the same address, then read.
   -> read returns 0x1122CC44; ram_wmask_o=4'b0010 during the second ACCESS cycle.
3. A and B raise read requests in the same cycle after reset, to different addresses holding 0xA5A5A5A5 and 0x5A5A5A5A.
   -> A acked first with 0xA5A5A5A5, then B with 0x5A5A5A5A.
   -> With both held requesting continuously, grants alternate A,B,A,B.
   -> The two ack signals are never high together.
4. Reset mid-read: assert wb_rstn_i=0 while in RDWAIT.
   -> ram_csb_o=1, both ack=0, both dat_o=0 with no clock edge needed.
   -> After release, a new port B read completes in 3 cycles.
5. Port B issues 8 back-to-back writes while port A continuously requests.
   -> Without WB_OPENRAM_ARB_PRIO_EN: B completes all 8 interleaved with A.
   -> With WB_OPENRAM_ARB_PRIO_EN: B receives no ack until A drops cyc.
